// File: rtl/shift_reg_ctrl_pkg.sv
// Shared encodings for the LED shift register: switch modes, shift direction
// and a small helper for sizing counters.
package shift_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_LOGIC = 2'b00,
    MODE_ROT   = 2'b01,
    MODE_ARITH = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_reg_ctrl_key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-sample debounce counter
// and a one-cycle press event on the released->pressed transition.
module key_debounce
  import shift_reg_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic pressed,
  output logic press_evt
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Raw key level that means "not pressed".
  localparam logic          RELEASED = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic          sync1_q, sync2_q;
  logic          state_q, state_d;   // debounced key level (raw polarity)
  logic [CW-1:0] cnt_q, cnt_d;
  logic          evt_q, evt_d;

  // Two-stage synchroniser; resets to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the debounced level; flip after DEBOUNCE_CYCLES of them.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    evt_d   = 1'b0;
    if (sync2_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      state_d = sync2_q;
      evt_d   = (sync2_q != RELEASED);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Debounce state, counter and the registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign pressed   = (state_q != RELEASED);
  assign press_evt = evt_q;

endmodule

// File: rtl/shift_reg_ctrl.sv
// Button-driven LED shift register: debounced clear/shift keys, selectable
// direction and logical/rotate/arithmetic/hold modes, saturating fill counter.
module shift_reg_ctrl
  import shift_reg_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       key_clr,
  input  logic                       key_shift,
  input  logic                       sw_data,
  input  logic                       sw_dir,
  input  logic [1:0]                 sw_mode,
  output logic [WIDTH-1:0]           leds,
  output logic [$clog2(WIDTH+1)-1:0] fill_cnt,
  output logic                       full
);

  localparam int unsigned   FW       = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(WIDTH);

  logic             clr_evt, shift_evt;
  logic             clr_pressed, shift_pressed;
  logic             unused_pressed;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic [FW-1:0]    fill_q, fill_d;
  mode_e            mode;
  dir_e             dir;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
  ) u_clr_key (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key_clr),
    .pressed   (clr_pressed),
    .press_evt (clr_evt)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
  ) u_shift_key (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key_shift),
    .pressed   (shift_pressed),
    .press_evt (shift_evt)
  );

  // Only press events drive the register; the held levels are collected into one sink.
  assign unused_pressed = clr_pressed ^ shift_pressed;

  // Switches are static user settings, so they are used without synchronisation.
  assign mode = mode_e'(sw_mode);
  assign dir  = dir_e'(sw_dir);

  // Next register/counter value; clear takes priority over a coincident shift.
  always_comb begin
    leds_d = leds_q;
    fill_d = fill_q;
    if (clr_evt) begin
      leds_d = '0;
      fill_d = '0;
    end else if (shift_evt) begin
      unique case (mode)
        MODE_LOGIC: begin
          leds_d = (dir == DIR_LEFT) ? {leds_q[WIDTH-2:0], sw_data}
                                     : {sw_data, leds_q[WIDTH-1:1]};
          if (fill_q != FILL_MAX) begin
            fill_d = fill_q + FW'(1);
          end
        end
        MODE_ROT: begin
          leds_d = (dir == DIR_LEFT) ? {leds_q[WIDTH-2:0], leds_q[WIDTH-1]}
                                     : {leds_q[0], leds_q[WIDTH-1:1]};
        end
        MODE_ARITH: begin
          leds_d = (dir == DIR_LEFT) ? {leds_q[WIDTH-2:0], 1'b0}
                                     : {leds_q[WIDTH-1], leds_q[WIDTH-1:1]};
        end
        MODE_HOLD: begin
          leds_d = leds_q;
        end
        default: begin
          leds_d = leds_q;
        end
      endcase
    end
  end

  // LED register and fill counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_q <= '0;
      fill_q <= '0;
    end else begin
      leds_q <= leds_d;
      fill_q <= fill_d;
    end
  end

  assign leds     = leds_q;
  assign fill_cnt = fill_q;
  assign full     = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench for shift_reg_ctrl (WIDTH=8, DEBOUNCE_CYCLES=4, active-low keys).
module tb_shift_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_clr = 1'b1;
  logic       key_shift = 1'b1;
  logic       sw_data = 1'b0;
  logic       sw_dir = 1'b0;
  logic [1:0] sw_mode = 2'b00;
  logic [7:0] leds;
  logic [3:0] fill_cnt;
  logic       full;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what the LEDs and fill count should be.
  logic [7:0] leds_m = 8'h00;
  logic [3:0] fill_m = 4'd0;

  shift_reg_ctrl #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (4),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_clr   (key_clr),
    .key_shift (key_shift),
    .sw_data   (sw_data),
    .sw_dir    (sw_dir),
    .sw_mode   (sw_mode),
    .leds      (leds),
    .fill_cnt  (fill_cnt),
    .full      (full)
  );

  always #5 clk = ~clk;

  // Behavioural model of one accepted shift press, computed with plain arithmetic.
  task automatic model_shift(input bit d, input bit dir, input int mode);
    int l;
    l = int'(leds_m);
    case (mode)
      0: begin
        l = dir ? (int'(d) * 128 + l / 2) : ((l * 2 + int'(d)) % 256);
        if (fill_m < 4'd8) fill_m = fill_m + 4'd1;
      end
      1: l = dir ? ((l % 2) * 128 + l / 2) : ((l * 2) % 256 + l / 128);
      2: l = dir ? ((l / 128) * 128 + l / 2) : ((l * 2) % 256);
      default: ;
    endcase
    leds_m = l[7:0];
  endtask

  // Full shift-key press and release, long enough for both debounce transitions.
  task automatic do_shift(input bit d, input bit dir, input int mode);
    @(negedge clk);
    sw_data = d; sw_dir = dir; sw_mode = 2'(mode);
    key_shift = 1'b0;
    repeat (8) @(negedge clk);
    key_shift = 1'b1;
    repeat (8) @(negedge clk);
    model_shift(d, dir, mode);
    $display("shift d=%0d dir=%0d mode=%0d -> leds=%02h fill=%0d", d, dir, mode, leds, fill_cnt);
  endtask

  task automatic do_clear();
    @(negedge clk);
    key_clr = 1'b0;
    repeat (8) @(negedge clk);
    key_clr = 1'b1;
    repeat (8) @(negedge clk);
    leds_m = 8'h00;
    fill_m = 4'd0;
    $display("clear -> leds=%02h fill=%0d", leds, fill_cnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    if (leds !== 8'h00) begin $display("FAIL reset_leds got=%02h exp=00", leds); n_err++; end
    n_cmp++;
    if (fill_cnt !== 4'd0) begin $display("FAIL reset_fill got=%0d exp=0", fill_cnt); n_err++; end
    n_cmp++;
    if (full !== 1'b0) begin $display("FAIL reset_full got=%0b exp=0", full); n_err++; end
    n_cmp++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset released -> leds=%02h fill=%0d", leds, fill_cnt);
  endtask

  // Left/logical shifts of 1,0,1 with exact update-edge checks.
  task automatic test_logical_fill();
    bit bits [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] prev;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sw_data = bits[i]; sw_dir = 1'b0; sw_mode = 2'b00;
      key_shift = 1'b0;
      prev = leds_m;
      model_shift(bits[i], 1'b0, 0);
      repeat (6) @(posedge clk);   // E0 .. E0+5
      #1;
      if (leds !== prev) begin $display("FAIL latency_early[%0d] got=%02h exp=%02h", i, leds, prev); n_err++; end
      n_cmp++;
      @(posedge clk);              // E0+6
      #1;
      if (leds !== leds_m) begin $display("FAIL latency_update[%0d] got=%02h exp=%02h", i, leds, leds_m); n_err++; end
      n_cmp++;
      repeat (2) @(negedge clk);
      key_shift = 1'b1;
      repeat (8) @(negedge clk);
      $display("shift d=%0d left logical -> leds=%02h fill=%0d", bits[i], leds, fill_cnt);
    end
    if (leds !== 8'h05) begin $display("FAIL logical_leds got=%02h exp=05", leds); n_err++; end
    n_cmp++;
    if (fill_cnt !== 4'd3) begin $display("FAIL logical_fill got=%0d exp=3", fill_cnt); n_err++; end
    n_cmp++;
  endtask

  task automatic test_saturate();
    do_clear();
    for (int i = 0; i < 9; i++) do_shift(1'b1, 1'b0, 0);
    if (leds !== 8'hFF) begin $display("FAIL sat_leds got=%02h exp=ff", leds); n_err++; end
    n_cmp++;
    if (fill_cnt !== 4'd8) begin $display("FAIL sat_fill got=%0d exp=8", fill_cnt); n_err++; end
    n_cmp++;
    if (full !== 1'b1) begin $display("FAIL sat_full got=%0b exp=1", full); n_err++; end
    n_cmp++;
  endtask

  task automatic test_rotate_arith();
    // 0x03 rotated right -> 0x81, then again -> 0xC0
    do_clear();
    do_shift(1'b1, 1'b0, 0);
    do_shift(1'b1, 1'b0, 0);
    do_shift(1'b0, 1'b1, 1);
    if (leds !== 8'h81) begin $display("FAIL rot_setup got=%02h exp=81", leds); n_err++; end
    n_cmp++;
    do_shift(1'b0, 1'b1, 1);
    if (leds !== 8'hC0) begin $display("FAIL rot_right got=%02h exp=c0", leds); n_err++; end
    n_cmp++;
    if (fill_cnt !== 4'd2) begin $display("FAIL rot_fill got=%0d exp=2", fill_cnt); n_err++; end
    n_cmp++;
    // arithmetic left from 0x81
    do_clear();
    do_shift(1'b1, 1'b0, 0);
    do_shift(1'b1, 1'b0, 0);
    do_shift(1'b0, 1'b1, 1);
    do_shift(1'b1, 1'b0, 2);
    if (leds !== 8'h02) begin $display("FAIL arith_left got=%02h exp=02", leds); n_err++; end
    n_cmp++;
    if (fill_cnt !== 4'd2) begin $display("FAIL arith_left_fill got=%0d exp=2", fill_cnt); n_err++; end
    n_cmp++;
    // arithmetic right from 0x80
    do_clear();
    do_shift(1'b1, 1'b1, 0);
    do_shift(1'b0, 1'b1, 2);
    if (leds !== 8'hC0) begin $display("FAIL arith_right got=%02h exp=c0", leds); n_err++; end
    n_cmp++;
    if (fill_cnt !== 4'd1) begin $display("FAIL arith_right_fill got=%0d exp=1", fill_cnt); n_err++; end
    n_cmp++;
  endtask

  task automatic test_bounce();
    @(negedge clk);
    sw_data = 1'b1; sw_dir = 1'b0; sw_mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      key_shift = 1'b0;
      repeat (3) @(negedge clk);
      key_shift = 1'b1;
      repeat (3) @(negedge clk);
    end
    key_shift = 1'b0;
    repeat (2) @(negedge clk);
    key_shift = 1'b1;
    repeat (10) @(negedge clk);
    $display("bounce pulses -> leds=%02h fill=%0d", leds, fill_cnt);
    if (leds !== leds_m) begin $display("FAIL bounce_leds got=%02h exp=%02h", leds, leds_m); n_err++; end
    n_cmp++;
    if (fill_cnt !== fill_m) begin $display("FAIL bounce_fill got=%0d exp=%0d", fill_cnt, fill_m); n_err++; end
    n_cmp++;
    // exactly DEBOUNCE_CYCLES samples pressed -> one shift
    key_shift = 1'b0;
    repeat (4) @(negedge clk);
    key_shift = 1'b1;
    repeat (10) @(negedge clk);
    model_shift(1'b1, 1'b0, 0);
    $display("hold 4 -> leds=%02h fill=%0d", leds, fill_cnt);
    if (leds !== leds_m) begin $display("FAIL hold4_leds got=%02h exp=%02h", leds, leds_m); n_err++; end
    n_cmp++;
    // long hold -> still one shift
    key_shift = 1'b0;
    repeat (100) @(negedge clk);
    key_shift = 1'b1;
    repeat (10) @(negedge clk);
    model_shift(1'b1, 1'b0, 0);
    $display("hold 100 -> leds=%02h fill=%0d", leds, fill_cnt);
    if (leds !== leds_m) begin $display("FAIL hold100_leds got=%02h exp=%02h", leds, leds_m); n_err++; end
    n_cmp++;
    if (fill_cnt !== fill_m) begin $display("FAIL hold100_fill got=%0d exp=%0d", fill_cnt, fill_m); n_err++; end
    n_cmp++;
  endtask

  task automatic test_simultaneous();
    do_shift(1'b1, 1'b0, 0);
    @(negedge clk);
    sw_data = 1'b1; sw_dir = 1'b0; sw_mode = 2'b00;
    key_clr = 1'b0; key_shift = 1'b0;
    repeat (8) @(negedge clk);
    key_clr = 1'b1; key_shift = 1'b1;
    repeat (8) @(negedge clk);
    leds_m = 8'h00; fill_m = 4'd0;
    $display("clear+shift -> leds=%02h fill=%0d", leds, fill_cnt);
    if (leds !== 8'h00) begin $display("FAIL clr_wins_leds got=%02h exp=00", leds); n_err++; end
    n_cmp++;
    if (fill_cnt !== 4'd0) begin $display("FAIL clr_wins_fill got=%0d exp=0", fill_cnt); n_err++; end
    n_cmp++;
    do_shift(1'b1, 1'b0, 0);
    do_shift(1'b1, 1'b0, 0);
    do_shift(1'b1, 1'b0, 3);
    do_shift(1'b0, 1'b1, 3);
    if (leds !== 8'h03) begin $display("FAIL hold_mode_leds got=%02h exp=03", leds); n_err++; end
    n_cmp++;
    if (fill_cnt !== 4'd2) begin $display("FAIL hold_mode_fill got=%0d exp=2", fill_cnt); n_err++; end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    bit bits [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_clear();
    for (int i = 0; i < 8; i++) do_shift(bits[i], 1'b0, 0);
    if (leds !== 8'h3C) begin $display("FAIL rstmid_setup got=%02h exp=3c", leds); n_err++; end
    n_cmp++;
    @(negedge clk);
    sw_data = 1'b1; sw_dir = 1'b0; sw_mode = 2'b00;
    key_shift = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    if (leds !== 8'h00) begin $display("FAIL rstmid_async got=%02h exp=00", leds); n_err++; end
    n_cmp++;
    @(negedge clk);
    key_shift = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    leds_m = 8'h00; fill_m = 4'd0;
    repeat (20) @(negedge clk);
    $display("reset mid-debounce -> leds=%02h fill=%0d", leds, fill_cnt);
    if (leds !== 8'h00) begin $display("FAIL rstmid_noevt got=%02h exp=00", leds); n_err++; end
    n_cmp++;
    if (fill_cnt !== 4'd0) begin $display("FAIL rstmid_fill got=%0d exp=0", fill_cnt); n_err++; end
    n_cmp++;
    do_shift(1'b1, 1'b0, 0);
    if (leds !== 8'h01) begin $display("FAIL rstmid_repress got=%02h exp=01", leds); n_err++; end
    n_cmp++;
  endtask

  task automatic test_random();
    bit d, dir;
    int mode;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_clear();
      end else begin
        d    = 1'($urandom_range(0, 1));
        dir  = 1'($urandom_range(0, 1));
        mode = int'($urandom_range(0, 3));
        do_shift(d, dir, mode);
      end
      if (leds !== leds_m) begin $display("FAIL rand_leds[%0d] got=%02h exp=%02h", i, leds, leds_m); n_err++; end
      n_cmp++;
      if (fill_cnt !== fill_m) begin $display("FAIL rand_fill[%0d] got=%0d exp=%0d", i, fill_cnt, fill_m); n_err++; end
      n_cmp++;
      if (full !== (fill_m == 4'd8)) begin $display("FAIL rand_full[%0d] got=%0b exp=%0b", i, full, (fill_m == 4'd8)); n_err++; end
      n_cmp++;
    end
  endtask

  initial begin
    test_reset();
    test_logical_fill();
    test_saturate();
    test_rotate_arith();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
